lbp_scan_ctrl: RTL
==================

// Module: lbp_scan_ctrl
// PURPOSE
//  Scan controller directly upstream of the gray address calculator. Walks the LBP
//  window centre over all interior pixels of a 128x128 image in snake order.
//  Generates the initialize, fill_right, fill_left, fill_down, cycle, gray_addr_en and
//  lbp_addr controls that the address calculator consumes, plus lbp_valid and finish.
//  Centre coordinates run from (1,1) to (126,1); the whole image is never re-read.
// PARAMETERS
//  COORD_W   7    row/column coordinate width; lbp_addr = {row, col}
//  IMG_SIZE  128  image side in pixels; interior range is 1..IMG_SIZE-2
// PORTS
//  clk           in   1          clock, rising edge
//  reset         in   1          asynchronous, active-low reset
//  gray_ready    in   1          gray memory ready; low stalls address generation
//  gray_req      out  1          gray read request, high in INIT and FILL
//  initialize    out  1          high in INIT only
//  fill_right    out  1          move direction flags; one-hot or all zero
//  fill_left     out  1
//  fill_down     out  1
//  cycle         out  4          fetch index: 1..9 in INIT, 1..3 in FILL, 0 otherwise
//  gray_addr_en  out  1          high in FILL while gray_ready=1
//  lbp_addr      out  2*COORD_W  current window centre {row, col}
//  lbp_valid     out  1          one-cycle pulse; window at lbp_addr is complete
//  finish        out  1          high in DONE, held until reset
//  lbp_count     out  14         number of lbp_valid pulses (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, lbp_addr={1,1}, dir=RIGHT, cycle=0, all
//   other outputs 0. Reset asserted mid-scan aborts immediately; the scan restarts from
//   IDLE after release.
//  All outputs are registered except initialize, gray_req, gray_addr_en and the
//   lbp_valid/finish state decodes.
//  States:
//   IDLE : cycle=0; gray_ready=1 -> INIT with cycle=1.
//   INIT : initialize=1; cycle steps 1..9, one per clock, while gray_ready=1;
//          gray_ready=0 freezes cycle. Leave to CALC after cycle=9 is presented.
//   CALC : lbp_valid=1 for one clock. If lbp_addr={126,1} -> DONE, else -> MOVE.
//   MOVE : one clock. Update lbp_addr and assert exactly one fill flag:
//          dir=RIGHT, col<126 -> col+1, fill_right
//          dir=LEFT,  col>1   -> col-1, fill_left
//          else               -> row+1, fill_down, dir toggles.
//          Then cycle=1 -> FILL.
//   FILL : gray_addr_en=gray_ready; cycle steps 1..3 only when gray_ready=1.
//          After cycle=3 is accepted -> DRAIN.
//   DRAIN: one clock, cycle=0; this clock covers the registered-address latency of
//          the address calculator. Then -> CALC.
//   DONE : finish=1; stay until reset.
//  The fill flag is set in MOVE and held through FILL and DRAIN. It clears on CALC
//   entry.
//  Timing: the first lbp_valid comes 10 clocks after INIT entry when there are no
//   stalls. Without stalls, consecutive lbp_valid pulses are 6 clocks apart
//   (MOVE+3xFILL+DRAIN+CALC).
//  Arithmetic: COORD_W unsigned. Bounds checks happen before the update, so row/col
//   never leave the 1..126 range.
//  Simultaneous events: gray_ready falling on the clock cycle=3 would advance holds
//   FILL at cycle=3.
// CONFIGURATION
//  LBP_COUNT_EN defined: lbp_count increments on every lbp_valid. It resets to 0 and
//   saturates at 14'h3FFF.
//  LBP_COUNT_EN undefined: lbp_count is tied to 0 and no counter logic is built.
// TESTING
//  1 Reset low, then release with gray_ready=1 -> INIT with cycle 1..9 and
//    initialize=1; lbp_valid on clock 10 with lbp_addr=14'h0081.
//  2 Free run -> lbp_addr sequence 0x0081, 0x0082 ... 0x00FE; then fill_down with
//    0x017E; then fill_left with 0x017D.
//  3 Full scan -> exactly 15876 lbp_valid pulses; last lbp_addr=14'h3F01; finish=1
//    and stays high; lbp_count=15876 with LBP_COUNT_EN.
//  4 gray_ready=0 for 5 clocks at FILL cycle=2 -> cycle holds at 2 and
//    gray_addr_en=0; the gap between lbp_valid pulses stretches to 11 clocks.
//  5 reset=0 asynchronously during FILL at lbp_addr=0x0105 -> outputs clear at once;
//    after release lbp_addr=0x0081 and the scan restarts.
//  6 Build without LBP_COUNT_EN and run a full scan -> lbp_count=0 throughout; other
//    outputs match scenario 3.

Source files
------------

// File: rtl/lbp_scan_ctrl.sv
// Snake-order scan controller feeding the gray address calculator.
// Define LBP_COUNT_EN to build the saturating lbp_valid counter.
module lbp_scan_ctrl #(
   parameter int COORD_W  = 7,
   parameter int IMG_SIZE = 128
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               gray_ready,
   output logic               gray_req,
   output logic               initialize,
   output logic               fill_right,
   output logic               fill_left,
   output logic               fill_down,
   output logic [3:0]         cycle,
   output logic               gray_addr_en,
   output logic [2*COORD_W-1:0] lbp_addr,
   output logic               lbp_valid,
   output logic               finish,
   output logic [13:0]        lbp_count
);

   localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
   localparam logic [COORD_W-1:0] MAXC = COORD_W'(IMG_SIZE - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_CALC,
      S_MOVE,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state;
   logic [COORD_W-1:0] row;
   logic [COORD_W-1:0] col;
   logic               dir_left;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         row        <= ONE;
         col        <= ONE;
         dir_left   <= 1'b0;
         cycle      <= 4'd0;
         fill_right <= 1'b0;
         fill_left  <= 1'b0;
         fill_down  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (gray_ready) begin
                  state <= S_INIT;
                  cycle <= 4'd1;
               end
            end
            S_INIT: begin
               if (gray_ready) begin
                  if (cycle == 4'd9) begin
                     state <= S_CALC;
                     cycle <= 4'd0;
                  end else begin
                     cycle <= cycle + 4'd1;
                  end
               end
            end
            S_CALC: begin
               if (row == MAXC && col == ONE)
                  state <= S_DONE;
               else
                  state <= S_MOVE;
            end
            S_MOVE: begin
               // bounds are tested on the old position, so no overshoot
               if (!dir_left && col < MAXC) begin
                  col        <= col + ONE;
                  fill_right <= 1'b1;
               end else if (dir_left && col > ONE) begin
                  col       <= col - ONE;
                  fill_left <= 1'b1;
               end else begin
                  row       <= row + ONE;
                  fill_down <= 1'b1;
                  dir_left  <= ~dir_left;
               end
               cycle <= 4'd1;
               state <= S_FILL;
            end
            S_FILL: begin
               if (gray_ready) begin
                  if (cycle == 4'd3) begin
                     state <= S_DRAIN;
                     cycle <= 4'd0;
                  end else begin
                     cycle <= cycle + 4'd1;
                  end
               end
            end
            S_DRAIN: begin
               state      <= S_CALC;
               fill_right <= 1'b0;
               fill_left  <= 1'b0;
               fill_down  <= 1'b0;
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign initialize   = (state == S_INIT);
   assign gray_req     = (state == S_INIT) || (state == S_FILL);
   assign gray_addr_en = (state == S_FILL) && gray_ready;
   assign lbp_valid    = (state == S_CALC);
   assign finish       = (state == S_DONE);
   assign lbp_addr     = {row, col};

`ifdef LBP_COUNT_EN
   logic [13:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= 14'd0;
      else if (state == S_CALC && cnt != 14'h3FFF)
         cnt <= cnt + 14'd1;
   end

   assign lbp_count = cnt;
`else
   assign lbp_count = 14'd0;
`endif

endmodule
